// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the RV32IM front end.
package uarch_pkg;
   localparam int unsigned FETCH_WIDTH = 2;
   localparam int unsigned INST_W      = 32;

   typedef struct packed {
      logic [31:0]                        pc;
      logic [FETCH_WIDTH-1:0][INST_W-1:0] inst;
      logic [FETCH_WIDTH-1:0]             mask;
   } fetch_packet_t;

   function automatic logic [31:0] align8(input logic [31:0] a);
      return a & 32'hFFFF_FFF8;
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Icache request/response, backend redirect and decode handshake of the fetch stage.
interface fetch_unit_if;
   import uarch_pkg::*;

   logic [31:0]         icache_addr;
   logic                icache_re;
   logic                icache_stall;
   logic [2*INST_W-1:0] icache_dout;
   logic                icache_dout_val;
   logic                redirect_val;
   logic [31:0]         redirect_pc;
   logic                fb_valid;
   logic                fb_ready;
   logic [31:0]         fb_pc;
   logic [INST_W-1:0]   fb_inst0;
   logic [INST_W-1:0]   fb_inst1;
   logic [1:0]          fb_mask;

   modport master (
      output icache_addr, icache_re, fb_valid, fb_pc, fb_inst0, fb_inst1, fb_mask,
      input  icache_stall, icache_dout, icache_dout_val, redirect_val, redirect_pc, fb_ready
   );

   modport slave (
      input  icache_addr, icache_re, fb_valid, fb_pc, fb_inst0, fb_inst1, fb_mask,
      output icache_stall, icache_dout, icache_dout_val, redirect_val, redirect_pc, fb_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetch packets with flush; pointers carry one extra wrap bit.
module fetch_buffer
   import uarch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  fetch_packet_t wdata,
   input  logic          pop,
   output fetch_packet_t head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   fetch_packet_t mem [DEPTH];
   logic          do_pop;

   always_comb begin
      count  = wptr - rptr;
      empty  = (wptr == rptr);
      full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      do_pop = pop && !empty;
      head   = mem[rptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push)   wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
      end
   end

   // Storage is not reset; only the pointers define occupancy.
   always_ff @(posedge clk) begin
      if (rst && !flush && push) mem[wptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/fetch_unit.sv
// 2-wide fetch stage: PC generation, credit-limited icache requests, packet buffering, redirect squash.
module fetch_unit
   import uarch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned FB_DEPTH = 4,
   parameter int unsigned MAX_OUT  = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master fif
);
   localparam int unsigned OW = $clog2(MAX_OUT + 1);
   localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CW = $clog2(FB_DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] out_nxt;
   logic [OW-1:0] drop_cnt;
   logic [31:0]   tag_q [MAX_OUT];
   logic [TW-1:0] tag_wr;
   logic [TW-1:0] tag_rd;

   logic          issue;
   logic          accept;
   logic          resp;
   logic          push;
   logic          pop;
   logic          valid;
   fetch_packet_t pkt;
   fetch_packet_t head;
   logic [CW-1:0] fb_count;
   logic          fb_full;
   logic          fb_empty;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      // A response with nothing outstanding can only be pre-reset residue.
      resp    = fif.icache_dout_val && (outstanding != '0);
      issue   = rst && !fif.redirect_val && (outstanding < OW'(MAX_OUT)) &&
                ((32'(fb_count) + 32'(outstanding)) < 32'(FB_DEPTH));
      accept  = issue && !fif.icache_stall;
      out_nxt = outstanding + OW'(accept) - OW'(resp);
      push    = resp && (drop_cnt == '0) && !fif.redirect_val;
      valid   = rst && !fb_empty;
      pop     = valid && fif.fb_ready && !fif.redirect_val;

      pkt.pc      = align8(tag_q[tag_rd]);
      pkt.inst[0] = fif.icache_dout[INST_W-1:0];
      pkt.inst[1] = fif.icache_dout[2*INST_W-1:INST_W];
      pkt.mask    = tag_q[tag_rd][2] ? 2'b10 : 2'b11;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
      end else begin
         outstanding <= out_nxt;
         if (fif.redirect_val) begin
            fetch_pc <= fif.redirect_pc & 32'hFFFF_FFFC;
            drop_cnt <= out_nxt;
         end else begin
            if (accept) fetch_pc <= align8(fetch_pc) + 32'd8;
            if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
         end
         if (accept) tag_wr <= tag_inc(tag_wr);
         if (resp)   tag_rd <= tag_inc(tag_rd);
      end
   end

   // Tag entries survive a redirect so squashed responses still retire in order.
   always_ff @(posedge clk) begin
      if (rst && accept) tag_q[tag_wr] <= fetch_pc;
   end

   fetch_buffer #(.DEPTH(FB_DEPTH)) u_fb (
      .clk   (clk),
      .rst   (rst),
      .flush (fif.redirect_val),
      .push  (push),
      .wdata (pkt),
      .pop   (pop),
      .head  (head),
      .count (fb_count),
      .full  (fb_full),
      .empty (fb_empty)
   );

   always_comb begin
      fif.icache_addr = rst ? align8(fetch_pc) : align8(RESET_PC);
      fif.icache_re   = issue;
      fif.fb_valid    = valid;
      fif.fb_pc       = head.pc;
      fif.fb_inst0    = head.inst[0];
      fif.fb_inst1    = head.inst[1];
      fif.fb_mask     = valid ? head.mask : '0;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && fb_full && !pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order icache model with variable latency.
module tb_fetch_unit;
   import uarch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] epc;
      logic [1:0]  emask;
      int          due;
      bit          live;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] i0;
      logic [31:0] i1;
      logic [1:0]  mask;
   } epkt_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   fetch_unit_if fif();

   fetch_unit #(.RESET_PC(RST_PC), .FB_DEPTH(4), .MAX_OUT(2)) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
   );

   always #5 clk = ~clk;

   mreq_t mq[$];
   epkt_t sb[$];
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int lat = 1;
   int acc_cnt = 0;
   int pop_cnt = 0;
   logic [31:0] exp_pc = RST_PC;

   logic        rst_v = 1'b0, stall_v = 1'b0, ready_v = 1'b0, redir_v = 1'b0;
   logic [31:0] redir_pc_v = '0;
   logic        s_re, s_valid;
   logic [31:0] s_addr, s_pc, s_i0, s_i1;
   logic [1:0]  s_mask;
   bit          resp_now;

   function automatic logic [31:0] mw(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1234};
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      mreq_t e;
      epkt_t p;
      bit    resp_live;
      @(negedge clk);
      cyc++;
      rst                 = rst_v;
      fif.icache_stall    = stall_v;
      fif.fb_ready        = ready_v;
      fif.redirect_val    = redir_v;
      fif.redirect_pc     = redir_pc_v;
      fif.icache_dout_val = 1'b0;
      fif.icache_dout     = '0;
      resp_now  = 0;
      resp_live = 0;
      if (!rst_v) begin
         mq.delete();
         sb.delete();
         exp_pc = RST_PC;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
         e = mq.pop_front();
         fif.icache_dout_val = 1'b1;
         fif.icache_dout     = {mw(e.addr + 32'd4), mw(e.addr)};
         resp_now  = 1;
         resp_live = e.live && !redir_v;
      end
      #1;
      s_re = fif.icache_re;    s_addr = fif.icache_addr;
      s_valid = fif.fb_valid;  s_pc = fif.fb_pc;
      s_i0 = fif.fb_inst0;     s_i1 = fif.fb_inst1;  s_mask = fif.fb_mask;
      if (rst_v) begin
         if (s_valid && ready_v && !redir_v) begin
            pop_cnt++;
            if (sb.size() == 0) chk("unexpected_pkt", s_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               p = sb.pop_front();
               chk("pkt_pc", s_pc, p.pc);
               chk("pkt_i0", s_i0, p.i0);
               chk("pkt_i1", s_i1, p.i1);
               chk("pkt_mask", s_mask, p.mask);
            end
         end
         if (resp_live) begin
            p.pc = e.epc; p.i0 = mw(e.epc); p.i1 = mw(e.epc + 32'd4); p.mask = e.emask;
            sb.push_back(p);
         end
         if (redir_v) begin
            chk("re_in_redirect", s_re, 0);
            sb.delete();
            foreach (mq[i]) mq[i].live = 0;
            exp_pc = redir_pc_v & 32'hFFFF_FFFC;
         end else if (s_re && !stall_v) begin
            chk("req_addr", s_addr, exp_pc & 32'hFFFF_FFF8);
            e.addr = s_addr; e.epc = exp_pc & 32'hFFFF_FFF8;
            e.emask = exp_pc[2] ? 2'b10 : 2'b11;
            e.due = cyc + lat; e.live = 1;
            mq.push_back(e);
            exp_pc = (exp_pc & 32'hFFFF_FFF8) + 32'd8;
            acc_cnt++;
         end
      end
   endtask

   task automatic do_reset();
      rst_v = 1'b0; redir_v = 1'b0; stall_v = 1'b0;
      tick();
      chk("rst_re", s_re, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_mask", s_mask, 0);
      chk("rst_addr", s_addr, RST_PC & 32'hFFFF_FFF8);
      rst_v = 1'b1;
   endtask

   task automatic wait_valid_check(input string tag, input logic [31:0] pc, input logic [1:0] mask);
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (s_valid) begin
            found = 1;
            chk({tag, "_pc"}, s_pc, pc);
            chk({tag, "_mask"}, s_mask, mask);
         end
      end
      chk({tag, "_seen"}, found, 1);
   endtask

   initial begin
      int first_resp;
      int a0;
      bit found;
      fif.icache_stall = 1'b0; fif.icache_dout = '0; fif.icache_dout_val = 1'b0;
      fif.redirect_val = 1'b0; fif.redirect_pc = '0; fif.fb_ready = 1'b0;

      // Streaming at latency 1.
      do_reset();
      tick();
      lat = 1; ready_v = 1'b1; first_resp = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (first_resp < 0 && resp_now) begin
            first_resp = cyc;
            chk("valid_at_first_resp", s_valid, 0);
         end else if (first_resp >= 0 && cyc == first_resp + 1) begin
            chk("valid_after_first_resp", s_valid, 1);
         end
      end
      chk("stream_pops", pop_cnt >= 30, 1);

      // Back-pressure: credits bound requests to buffer depth.
      do_reset();
      lat = 2; ready_v = 1'b0; a0 = acc_cnt;
      repeat (15) tick();
      chk("bp_reqs", acc_cnt - a0, 4);
      chk("bp_re_low", s_re, 0);
      ready_v = 1'b1; tick(); ready_v = 1'b0;
      repeat (10) tick();
      chk("bp_one_more", acc_cnt - a0, 5);
      chk("bp_re_low2", s_re, 0);

      // Stall holds request steady.
      do_reset();
      lat = 1; ready_v = 1'b1;
      tick();
      stall_v = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_re", s_re, 1);
         chk("stall_addr", s_addr, 32'h8);
      end
      stall_v = 1'b0; a0 = acc_cnt;
      repeat (5) tick();
      chk("stall_after_acc", acc_cnt - a0, 5);

      // Redirect with two requests in flight, to an odd word.
      do_reset();
      lat = 3; ready_v = 1'b0; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mq.size() == 2 && s_valid) found = 1;
         else tick();
      end
      chk("redir_setup", found, 1);
      redir_v = 1'b1; redir_pc_v = 32'h0000_0104;
      tick();
      redir_v = 1'b0;
      tick();
      chk("redir_flushed", s_valid, 0);
      ready_v = 1'b1; lat = 1;
      wait_valid_check("redir_first", 32'h100, 2'b10);
      wait_valid_check("redir_second", 32'h108, 2'b11);
      repeat (10) tick();

      // Redirect coinciding with a response and a pop.
      do_reset();
      lat = 2; ready_v = 1'b0; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mq.size() >= 2 && mq[0].due == cyc + 1 && s_valid) found = 1;
         else tick();
      end
      chk("coinc_setup", found, 1);
      redir_v = 1'b1; redir_pc_v = 32'h0000_0200; ready_v = 1'b1;
      a0 = pop_cnt;
      tick();
      chk("coinc_resp", resp_now, 1);
      chk("coinc_no_pop", pop_cnt - a0, 0);
      redir_v = 1'b0; ready_v = 1'b0;
      tick();
      chk("coinc_flushed", s_valid, 0);
      ready_v = 1'b1;
      wait_valid_check("coinc_first", 32'h200, 2'b11);
      repeat (10) tick();

      // Reset pulse mid-stream with two outstanding.
      lat = 3; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mq.size() == 2) found = 1;
         else tick();
      end
      chk("midrst_setup", found, 1);
      do_reset();
      tick();
      chk("midrst_restart_re", s_re, 1);
      chk("midrst_restart_addr", s_addr, RST_PC);
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
2-wide instruction fetch stage of the OoO RV32IM core. Holds the fetch PC, issues aligned 8-byte requests on the core's icache port (icache_addr/icache_re/icache_dout/icache_dout_val/icache_stall), and buffers returned 2-instruction packets in a small FIFO. Decode drains the FIFO over a valid/ready interface. Backend redirects (branch mispredict, exception) flush the FIFO and squash in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FB_DEPTH, 4, fetch-buffer entries (one packet each), power of 2, >=2
MAX_OUT, 2, max outstanding icache requests, 1..FB_DEPTH

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous, active-low (rst==0 resets)
icache_addr  out  32  request address, always 8-byte aligned
icache_re  out  1  request valid
icache_stall  in  1  memory cannot accept a request this cycle
icache_dout  in  64  [31:0] = inst at addr, [63:32] = inst at addr+4
icache_dout_val  in  1  response valid; responses return in request order, latency >=1
redirect_val  in  1  backend redirect
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
fb_valid  out  1  packet available to decode
fb_ready  in  1  decode accepts packet
fb_pc  out  32  PC of packet slot 0 (8-byte aligned)
fb_inst0  out  32  slot 0 instruction
fb_inst1  out  32  slot 1 instruction
fb_mask  out  2  per-slot valid; bit0 = slot 0

Behaviour:
- Reset (rst==0 at a clock edge): fetch_pc<=RESET_PC, FIFO empty, outstanding<=0, drop_cnt<=0, start_odd<=RESET_PC[2]. Outputs while in reset: icache_re=0, fb_valid=0, fb_mask=0, icache_addr={RESET_PC[31:3],3'b0}. Reset during in-flight requests discards them; responses arriving after reset release are ignored until outstanding counts new requests only. Memory is reset together with the core.
- icache_addr = {fetch_pc[31:3],3'b000} (combinational from the register).
- Issue condition: rst==1 && !redirect_val && outstanding<MAX_OUT && (fb_count+outstanding)<FB_DEPTH. icache_re equals the issue condition.
- Request accepted when icache_re && !icache_stall. On accept: fetch_pc<={fetch_pc[31:3],3'b0}+8, outstanding++, record start_odd=fetch_pc[2] in an in-order tag queue (depth MAX_OUT). A stalled request holds addr and re steady (unless redirect).
- Response (icache_dout_val): outstanding--. If drop_cnt>0, drop_cnt-- and discard. Otherwise push {pc=addr of request, inst0, inst1, mask = start_odd ? 2'b10 : 2'b11}. The credit rule guarantees space. Push while full is an assertion failure.
- Decode handshake: pop when fb_valid && fb_ready. Head fields are registered FIFO outputs with no bypass, so a response at cycle N is visible on fb_* at cycle N+1 at the earliest. Simultaneous push and pop is allowed at any occupancy, including full.
- Redirect (redirect_val==1): FIFO flushed (fb_valid=0 next cycle; pops that cycle are ignored), fetch_pc<={redirect_pc[31:2],2'b0}, icache_re=0 that cycle, drop_cnt<=outstanding_after_this_cycle. Any response in the redirect cycle is discarded. First request to the new PC is issued the following cycle. Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Redirect to an odd word (pc[2]=1): the first packet has mask 2'b10 and fb_pc=pc&~7. Later packets have mask 2'b11.
- Wrap-around: fetch_pc+8 wraps modulo 2^32.
- Decode is responsible for ignoring slot 0 when mask[0]=0.

Decomposition:
- uarch_pkg: FETCH_WIDTH=2, INST_W=32, fetch_packet_t {logic [31:0] pc; logic [1:0][31:0] inst; logic [1:0] mask;}.
- Sub-module fetch_buffer: parameterised circular FIFO of fetch_packet_t with flush. Provides count, full/empty, head/tail pointers with one extra wrap bit.
- Tag queue and counters stay in fetch_unit.

Test Plan:
- Reset release, memory latency 1, fb_ready=1: requests 0x0,0x8,0x10…, packets with fb_pc 0x0,0x8, mask 2'b11, fb_valid first at the cycle after the first dout_val.
- fb_ready=0, latency 2: exactly FB_DEPTH=4 requests issued, then icache_re=0. Releasing fb_ready for one pop allows exactly one new request. No overflow.
- icache_stall=1 for 3 cycles: icache_re held high, icache_addr stable at 0x8. Stall drop: next address 0x10 is issued once.
- Two requests outstanding, redirect_pc=0x104: FIFO empty next cycle, both late responses discarded. The next packet has fb_pc=0x100, mask 2'b10, then 0x108 with mask 2'b11.
- Redirect in the same cycle as dout_val and an fb_ready pop: response dropped, no pop side effects, drop_cnt equals remaining outstanding.
- rst=0 for one cycle mid-stream with 2 outstanding: all outputs return to reset values and fetch restarts at RESET_PC.
